// File: rtl/multi_sum_sequencer_pkg.sv
// Shared state encoding and sizing helpers for the chunked summing sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package multi_sum_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Integer ceiling division, used to count chunks including a partial last one.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int log2_ceil(input int val);
    int res;
    res = 0;
    while ((1 << res) < val) res++;
    return res;
  endfunction

endpackage

// File: rtl/multi_sum_sequencer_adder.sv
// Combinational adder of VALUE_COUNT unsigned values, zero-extended to SUM_WIDTH.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the result follows the inputs.
module multi_sum #(
  parameter int VALUE_WIDTH = 8,
  parameter int VALUE_COUNT = 2,
  parameter int SUM_WIDTH   = 12
) (
  input  logic [VALUE_WIDTH*VALUE_COUNT-1:0] values,
  output logic [SUM_WIDTH-1:0]               sum
);

  // Sum every value in the chunk; the result wraps modulo 2^SUM_WIDTH.
  always_comb begin
    sum = '0;
    for (int k = 0; k < VALUE_COUNT; k++) begin
      sum = sum + SUM_WIDTH'(values[k*VALUE_WIDTH +: VALUE_WIDTH]);
    end
  end

endmodule

// File: rtl/multi_sum_sequencer.sv
// Sums a TOTAL_COUNT-value vector CHUNK_COUNT values per cycle and presents the total.
// Latency: out_valid rises NUM_CHUNKS cycles after the accepting edge.
// Backpressure: holds the result in DONE until out_ready; in_ready only in IDLE.
module multi_sum_sequencer
  import multi_sum_sequencer_pkg::*;
#(
  parameter int VALUE_WIDTH = 8,
  parameter int TOTAL_COUNT = 8,
  parameter int CHUNK_COUNT = 2,
  parameter int SUM_WIDTH   = 12
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [VALUE_WIDTH*TOTAL_COUNT-1:0] in_values,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SUM_WIDTH-1:0]               out_sum,
  output logic                               busy
);

  localparam int NUM_CHUNKS = ceil_div(TOTAL_COUNT, CHUNK_COUNT);
  localparam int IDX_W      = (log2_ceil(NUM_CHUNKS) > 1) ? log2_ceil(NUM_CHUNKS) : 1;
  localparam int CHUNK_W    = VALUE_WIDTH * CHUNK_COUNT;
  localparam int PAD_W      = CHUNK_W * NUM_CHUNKS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t                            state;
  state_t                            state_next;
  logic [VALUE_WIDTH*TOTAL_COUNT-1:0] values_reg;
  logic [PAD_W-1:0]                  values_pad;
  logic [CHUNK_W-1:0]                chunk_values;
  logic [SUM_WIDTH-1:0]              chunk_sum;
  logic [SUM_WIDTH-1:0]              acc;
  logic [IDX_W-1:0]                  idx;
  logic                              load;
  logic                              add;

  // Zero-extension fills the unused slots of a partial last chunk with zeros.
  assign values_pad = PAD_W'(values_reg);

  // Select the chunk addressed by the current index from the registered copy.
  always_comb begin
    chunk_values = values_pad[int'(idx)*CHUNK_W +: CHUNK_W];
  end

  multi_sum #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .VALUE_COUNT (CHUNK_COUNT),
    .SUM_WIDTH   (SUM_WIDTH)
  ) u_multi_sum (
    .values (chunk_values),
    .sum    (chunk_sum)
  );

  // State register; reset discards any in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and control decode; handshake outputs depend on state only.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    add        = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          load       = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        add = 1'b1;
        if (idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the vector on accept, then accumulate one chunk per ACCUM cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      values_reg <= '0;
      acc        <= '0;
      idx        <= '0;
    end else if (load) begin
      values_reg <= in_values;
      acc        <= '0;
      idx        <= '0;
    end else if (add) begin
      acc <= acc + chunk_sum;
      idx <= idx + IDX_W'(1);
    end
  end

  assign out_sum = acc;

endmodule

// File: tb/tb_multi_sum_sequencer.sv
// Self-checking bench: default, narrow-sum and partial-chunk instances of the sequencer.
// Latency: checks out_valid timing relative to the accepting edge.
// Backpressure: exercises held results, ignored inputs and mid-operation reset.
module tb_multi_sum_sequencer;

  logic clk;
  logic rst_n;

  // u0: defaults (8 x 8-bit, chunk 2, 12-bit sum)
  logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [63:0] in_values0;
  logic [11:0] out_sum0;
  // u1: 10-bit sum for wrap
  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [63:0] in_values1;
  logic [9:0]  out_sum1;
  // u2: 5 values, chunk 2 (partial last chunk)
  logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [39:0] in_values2;
  logic [11:0] out_sum2;

  int checks   = 0;
  int failures = 0;
  int unsigned q0[$];
  int unsigned q1[$];
  int unsigned q2[$];

  multi_sum_sequencer u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_values(in_values0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_sum(out_sum0), .busy(busy0)
  );

  multi_sum_sequencer #(.SUM_WIDTH(10)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_values(in_values1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .busy(busy1)
  );

  multi_sum_sequencer #(.TOTAL_COUNT(5), .CHUNK_COUNT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_values(in_values2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_sum(out_sum2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned model_sum(input logic [63:0] v, input int n, input int sw);
    int unsigned s;
    s = 0;
    for (int k = 0; k < n; k++) s += v[k*8 +: 8];
    return s & ((32'd1 << sw) - 1);
  endfunction

  // Wait (bounded) for out_valid of the chosen instance; lat counts cycles waited.
  task automatic wait_out(input int which, output int lat);
    logic v;
    lat = 0;
    v = (which == 0) ? out_valid0 : (which == 1) ? out_valid1 : out_valid2;
    while (v !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      v = (which == 0) ? out_valid0 : (which == 1) ? out_valid1 : out_valid2;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready0); end
    checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy0); end
    checks++; if (out_sum0 !== 12'd0) begin failures++; $display("FAIL reset_out_sum got=%0d want=0", out_sum0); end
    checks++; if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0) begin failures++; $display("FAIL reset_other_valid got=%b%b want=00", out_valid1, out_valid2); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    int unsigned exp;
    for (int k = 0; k < 8; k++) in_values0[k*8 +: 8] = 8'(k + 1);
    out_ready0 = 1'b1;
    in_valid0  = 1'b1;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL basic_in_ready_idle got=%b want=1", in_ready0); end
    q0.push_back(36);
    tick();
    in_valid0 = 1'b0;
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", busy0); end
    wait_out(0, lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL basic_latency got=%0d want=4", lat); end
    exp = (q0.size() > 0) ? q0.pop_front() : 32'hFFFF_FFFF;
    checks++; if (out_sum0 !== 12'(exp)) begin failures++; $display("FAIL basic_sum got=%0d want=%0d", out_sum0, exp); end
    checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL basic_in_ready_done got=%b want=0", in_ready0); end
    tick();
    checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b want=0", out_valid0); end
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL basic_in_ready_after got=%b want=1", in_ready0); end
  endtask

  task automatic test_wrap();
    int lat;
    int unsigned exp0, exp1;
    in_values0 = {8{8'hFF}};
    in_values1 = {8{8'hFF}};
    out_ready0 = 1'b1;
    out_ready1 = 1'b1;
    in_valid0  = 1'b1;
    in_valid1  = 1'b1;
    q0.push_back(2040);
    q1.push_back(1016);
    tick();
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    wait_out(1, lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL wrap_latency got=%0d want=4", lat); end
    exp1 = (q1.size() > 0) ? q1.pop_front() : 32'hFFFF_FFFF;
    checks++; if (out_sum1 !== 10'(exp1)) begin failures++; $display("FAIL wrap_sum10 got=%0d want=%0d", out_sum1, exp1); end
    checks++; if (out_valid0 !== 1'b1) begin failures++; $display("FAIL wrap_valid12 got=%b want=1", out_valid0); end
    exp0 = (q0.size() > 0) ? q0.pop_front() : 32'hFFFF_FFFF;
    checks++; if (out_sum0 !== 12'(exp0)) begin failures++; $display("FAIL wrap_sum12 got=%0d want=%0d", out_sum0, exp0); end
    tick();
  endtask

  task automatic test_partial();
    int lat;
    int unsigned exp;
    for (int k = 0; k < 5; k++) in_values2[k*8 +: 8] = 8'(k + 1);
    out_ready2 = 1'b1;
    in_valid2  = 1'b1;
    q2.push_back(15);
    tick();
    in_valid2 = 1'b0;
    wait_out(2, lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL partial_latency got=%0d want=3", lat); end
    exp = (q2.size() > 0) ? q2.pop_front() : 32'hFFFF_FFFF;
    checks++; if (out_sum2 !== 12'(exp)) begin failures++; $display("FAIL partial_sum got=%0d want=%0d", out_sum2, exp); end
    tick();
    checks++; if (in_ready2 !== 1'b1) begin failures++; $display("FAIL partial_in_ready got=%b want=1", in_ready2); end
  endtask

  task automatic test_backpressure();
    int lat;
    int unsigned exp;
    for (int k = 0; k < 8; k++) in_values0[k*8 +: 8] = 8'(10 * k + 3);
    q0.push_back(model_sum(in_values0, 8, 12));
    out_ready0 = 1'b0;
    in_valid0  = 1'b1;
    tick();
    in_valid0 = 1'b0;
    wait_out(0, lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL bp_latency got=%0d want=4", lat); end
    exp = (q0.size() > 0) ? q0.pop_front() : 32'hFFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      in_valid0  = 1'b1;
      in_values0 = {$urandom, $urandom};
      checks++; if (out_valid0 !== 1'b1) begin failures++; $display("FAIL bp_valid_held cyc=%0d got=%b want=1", c, out_valid0); end
      checks++; if (out_sum0 !== 12'(exp)) begin failures++; $display("FAIL bp_sum_stable cyc=%0d got=%0d want=%0d", c, out_sum0, exp); end
      checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", c, in_ready0); end
      tick();
    end
    checks++; if (out_sum0 !== 12'(exp)) begin failures++; $display("FAIL bp_sum_final got=%0d want=%0d", out_sum0, exp); end
    in_valid0  = 1'b0;
    out_ready0 = 1'b1;
    tick();
    checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin failures++; $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", out_valid0, in_ready0); end
    tick();
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL bp_no_accept busy got=%b want=0", busy0); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int unsigned exp;
    logic seen;
    in_values0 = {$urandom, $urandom};
    out_ready0 = 1'b1;
    in_valid0  = 1'b1;
    tick();
    in_valid0 = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b want=0", out_valid0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy0); end
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready0); end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid0 === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_result got=%b want=0", seen); end
    in_values0 = {8{8'h01}};
    q0.push_back(8);
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    wait_out(0, lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL rstmid_latency got=%0d want=4", lat); end
    exp = (q0.size() > 0) ? q0.pop_front() : 32'hFFFF_FFFF;
    checks++; if (out_sum0 !== 12'(exp)) begin failures++; $display("FAIL rstmid_sum got=%0d want=%0d", out_sum0, exp); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    int unsigned exp;
    for (int n = 0; n < 6; n++) begin
      lat = 0;
      while (in_ready0 !== 1'b1 && lat < 20) begin tick(); lat++; end
      in_values0 = {$urandom, $urandom};
      q0.push_back(model_sum(in_values0, 8, 12));
      out_ready0 = 1'b0;
      in_valid0  = 1'b1;
      tick();
      in_valid0 = 1'b0;
      wait_out(0, lat);
      checks++; if (lat != 4) begin failures++; $display("FAIL b2b_latency n=%0d got=%0d want=4", n, lat); end
      repeat ($urandom_range(0, 2)) tick();
      exp = (q0.size() > 0) ? q0.pop_front() : 32'hFFFF_FFFF;
      checks++; if (out_sum0 !== 12'(exp)) begin failures++; $display("FAIL b2b_sum n=%0d got=%0d want=%0d", n, out_sum0, exp); end
      out_ready0 = 1'b1;
      tick();
    end
    checks++; if (q0.size() != 0) begin failures++; $display("FAIL b2b_queue_left got=%0d want=0", q0.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b0; in_values0 = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in_values1 = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; in_values2 = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_partial();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
